// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module   : fifo_write_arbiter
// Brief    : Round-robin, burst-locking arbiter sharing one fifo write port
//            among NUM_REQ producers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int BURST   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_write_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in_data,
    output logic [NUM_REQ-1:0]         req_write_ready,
    output logic                       fifo_write_valid,
    input  logic                       fifo_write_ready,
    output logic [WIDTH-1:0]           fifo_in_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [31:0]                total_writes
);

    localparam int              OW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [OW:0]     C_NREQ      = (OW+1)'(NUM_REQ);
    localparam logic [OW-1:0]   C_OWNER_RST = OW'(NUM_REQ - 1);
    localparam logic [7:0]      C_LAST_BEAT = 8'(BURST - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [31:0]     total_q, total_d;

    logic [OW-1:0]   w_pick;
    logic            w_any_req;
    logic [OW:0]     w_scan;
    logic            w_owner_valid;
    logic            w_beat;

    // Rotating priority: first valid requester after last_owner, with wrap.
    always_comb begin
        w_pick    = last_owner_q;
        w_any_req = 1'b0;
        w_scan    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = {1'b0, last_owner_q} + (OW+1)'(k);
            if (w_scan >= C_NREQ) begin
                w_scan = w_scan - C_NREQ;
            end
            if (!w_any_req && req_write_valid[w_scan[OW-1:0]]) begin
                w_any_req = 1'b1;
                w_pick    = w_scan[OW-1:0];
            end
        end
    end

    assign busy          = (state_q == GRANT);
    assign w_owner_valid = req_write_valid[owner_q];
    assign w_beat        = busy & w_owner_valid & fifo_write_ready;
    assign total_writes  = total_q;

    always_comb begin
        req_write_ready  = '0;
        fifo_write_valid = 1'b0;
        fifo_in_data     = '0;
        grant            = '0;
        if (state_q == GRANT) begin
            fifo_write_valid         = w_owner_valid;
            req_write_ready[owner_q] = fifo_write_ready;
            grant[owner_q]           = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == OW'(i)) begin
                    fifo_in_data = req_in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        total_d      = total_q;
        case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    owner_d    = w_pick;
                    beat_cnt_d = 8'd0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (w_beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    total_d    = total_q + 32'd1;
                end
                // A full fifo with a valid owner falls through both arms and holds.
                if (!w_owner_valid || (w_beat && (beat_cnt_q == C_LAST_BEAT))) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= C_OWNER_RST;
            beat_cnt_q   <= 8'd0;
            total_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            total_q      <= total_d;
        end
    end

endmodule

`default_nettype wire
